motor_pwm_timebase: RTL and testbench
=====================================

Name: motor_pwm_timebase

Overview:
Shared timebase and shadow-register stage that sits directly upstream of the per-phase PWM generators (motor_pwm_phase). It produces the common period counter, and the period/duty/deadband values, that every phase instance consumes. New settings are staged by software and applied atomically only at a period wrap, so phase outputs never see a mid-period change. Stopping is glitch-free: the current period drains fully before the counter parks at 0.

Parameters:
SIZE, 16, width of counter, period, duty and deadband
PHASES, 3, number of duty channels
PRE_W, 8, prescaler width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  run request (level)
prescale_in  in  PRE_W  counter advances every prescale_in+1 clocks
period_in  in  SIZE  requested period in ticks
duty_in  in  PHASES*SIZE  requested duties; phase k occupies bits [k*SIZE +: SIZE]
deadband_in  in  SIZE  requested deadband
load_req  in  1  stage the *_in values for application at the next wrap
counter  out  SIZE  shared period counter, feeds phase blocks
period  out  SIZE  active period
duty  out  PHASES*SIZE  active duties
deadband  out  SIZE  active deadband
wrap  out  1  one-clock pulse on the clock where counter returns to 0
load_pending  out  1  staged set waiting for a wrap
load_done  out  1  one-clock pulse when the staged set becomes active
running  out  1  high in RUN and DRAIN

Behaviour:
- Reset (reset=0, asynchronous): all outputs and internal registers 0. State IDLE.
- States:
  - IDLE: counter held 0, running=0.
  - RUN: counter advancing.
  - DRAIN: RUN continuing until the next wrap.
- Tick generation:
  - Prescaler counter pre_cnt is cleared on entry to RUN and on every wrap.
  - A tick occurs when pre_cnt == active prescale; otherwise pre_cnt increments.
  - Active prescale is part of the shadowed set.
- IDLE->RUN on enable=1:
  - The same clock loads all *_in values directly into the active registers, with period clamped (see below).
  - Counter=0, running=1.
  - Any pending staged set is discarded: load_pending=0, no load_done.
- Counting, on each tick in RUN or DRAIN:
  - If counter >= period-1: counter<=0, wrap=1.
  - Else: counter<=counter+1.
  - With prescale 0, a period of P gives a counter sequence 0..P-1 and a wrap every P clocks.
  - The >= compare guarantees recovery if counter ever exceeds period.
- Period clamp: any period value below 2 is stored as 2, both at start and at a staged apply. Duty and deadband are passed through unclamped; range checking is the phase block's job.
- Staging handshake:
  - In RUN or DRAIN, with load_req=1 and load_pending=0: capture the *_in values (including prescale_in) into staging registers and set load_pending=1 on the next clock.
  - load_req while load_pending=1 is ignored; staging is not overwritten.
  - At a wrap with load_pending=1 (value before this clock): active<=staging, load_pending<=0, load_done=1 for one clock. The new period takes effect for the count beginning at 0.
  - Capture and wrap on the same clock: the capture happens, but application waits for the following wrap.
  - load_req in IDLE is ignored.
- Stop:
  - enable=0 in RUN -> DRAIN.
  - DRAIN at wrap -> IDLE with counter=0 and running=0 on the same clock the wrap pulse is issued.
  - A pending set is still applied at that final wrap.
  - enable=1 again during DRAIN -> RUN with no disturbance to the counter.
- Outputs are registered; no combinational path from any input to any output.
- A reset assertion mid-period immediately forces every output to its reset value.

Test Plan:
1. Basic count: period_in=1000, prescale_in=0, enable 0->1 -> counter 0..999; wrap pulses every 1000 clocks; period=1000 from the first RUN clock.
2. Prescale: prescale_in=3, period_in=10 -> counter changes every 4 clocks; wrap every 40 clocks.
3. Staged update: while running at period 1000, duty 500, pulse load_req with period_in=600 and duty_in[0]=300 at counter=200 -> load_pending=1; period/duty unchanged until counter 999->0; then load_done pulse, period=600, duty=300, next wrap 600 ticks later.
4. Load collision: second load_req with period_in=400 while pending -> ignored; period becomes 600, never 400. A load_req captured on the wrap clock -> applied at the following wrap.
5. Drain and restart: enable 1->0 at counter=300, period 1000 -> counting continues to 999, wrap, then counter=0 and running=0. In a second run, re-raise enable at counter=500 -> no stop; counting continues.
6. Edge and reset: period_in=0 -> period=2, counter toggles 0,1. reset low at counter=450 -> counter, period, duty and all flags 0 immediately; after release, stays IDLE until enable.

Source files
------------

// File: rtl/motor_pwm_timebase_if.sv
// motor_pwm_timebase_if: settings/handshake inputs and shared timebase outputs of motor_pwm_timebase.
interface motor_pwm_timebase_if #(
    parameter int SIZE   = 16,
    parameter int PHASES = 3,
    parameter int PRE_W  = 8
);
    logic                   enable;
    logic [PRE_W-1:0]       prescale_in;
    logic [SIZE-1:0]        period_in;
    logic [PHASES*SIZE-1:0] duty_in;
    logic [SIZE-1:0]        deadband_in;
    logic                   load_req;
    logic [SIZE-1:0]        counter;
    logic [SIZE-1:0]        period;
    logic [PHASES*SIZE-1:0] duty;
    logic [SIZE-1:0]        deadband;
    logic                   wrap;
    logic                   load_pending;
    logic                   load_done;
    logic                   running;

    modport master (
        output enable, prescale_in, period_in, duty_in, deadband_in, load_req,
        input  counter, period, duty, deadband, wrap, load_pending, load_done, running
    );

    modport slave (
        input  enable, prescale_in, period_in, duty_in, deadband_in, load_req,
        output counter, period, duty, deadband, wrap, load_pending, load_done, running
    );
endinterface

// File: rtl/motor_pwm_timebase.sv
// motor_pwm_timebase: shared PWM period counter with shadowed period/duty/deadband/prescale,
// applied atomically at period wrap, and a drain-to-wrap stop.
module motor_pwm_timebase #(
    parameter int SIZE   = 16,
    parameter int PHASES = 3,
    parameter int PRE_W  = 8
) (
    input logic                 clk,
    input logic                 reset,
    motor_pwm_timebase_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [SIZE-1:0]        cnt_q, per_q, db_q, stg_per_q, stg_db_q;
    logic [PHASES*SIZE-1:0] duty_q, stg_duty_q;
    logic [PRE_W-1:0]       pre_q, pre_cnt_q, stg_pre_q;
    logic                   pend_q, wrap_q, done_q, run_q;
    logic                   active, tick, wrap_d;
    logic [SIZE-1:0]        per_in_c;

    assign active   = state_q != IDLE;
    assign tick     = active && pre_cnt_q == pre_q;
    // >= rather than == so a counter left above a shrunk period still wraps
    assign wrap_d   = tick && cnt_q >= per_q - SIZE'(1);
    assign per_in_c = bus.period_in < SIZE'(2) ? SIZE'(2) : bus.period_in;

    always_comb
        state_d = state_q == IDLE ? (bus.enable ? RUN : IDLE)
                : bus.enable       ? RUN
                : state_q == RUN   ? DRAIN
                : wrap_d           ? IDLE : DRAIN;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            per_q      <= '0;
            duty_q     <= '0;
            db_q       <= '0;
            pre_q      <= '0;
            pre_cnt_q  <= '0;
            stg_per_q  <= '0;
            stg_duty_q <= '0;
            stg_db_q   <= '0;
            stg_pre_q  <= '0;
            pend_q     <= 1'b0;
            wrap_q     <= 1'b0;
            done_q     <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= state_d != IDLE;
            wrap_q  <= wrap_d;
            done_q  <= wrap_d && pend_q;
            if (!active) begin
                cnt_q     <= '0;
                pre_cnt_q <= '0;
                if (bus.enable) begin
                    per_q  <= per_in_c;
                    duty_q <= bus.duty_in;
                    db_q   <= bus.deadband_in;
                    pre_q  <= bus.prescale_in;
                    pend_q <= 1'b0;
                end
            end else begin
                if (tick) begin
                    cnt_q     <= wrap_d ? '0 : cnt_q + SIZE'(1);
                    pre_cnt_q <= '0;
                end else begin
                    pre_cnt_q <= pre_cnt_q + PRE_W'(1);
                end
                if (bus.load_req && !pend_q) begin
                    stg_per_q  <= per_in_c;
                    stg_duty_q <= bus.duty_in;
                    stg_db_q   <= bus.deadband_in;
                    stg_pre_q  <= bus.prescale_in;
                    pend_q     <= 1'b1;
                end
                // capture needs pend_q low and apply needs it high, so they never collide
                if (wrap_d && pend_q) begin
                    per_q  <= stg_per_q;
                    duty_q <= stg_duty_q;
                    db_q   <= stg_db_q;
                    pre_q  <= stg_pre_q;
                    pend_q <= 1'b0;
                end
            end
        end
    end

    assign bus.counter      = cnt_q;
    assign bus.period       = per_q;
    assign bus.duty         = duty_q;
    assign bus.deadband     = db_q;
    assign bus.wrap         = wrap_q;
    assign bus.load_pending = pend_q;
    assign bus.load_done    = done_q;
    assign bus.running      = run_q;
endmodule

// File: tb/tb_motor_pwm_timebase.sv
// tb_motor_pwm_timebase: directed stimulus with a wrap scoreboard; each expected wrap
// (gap, active period/duty, load_done, running) is queued when the stimulus causing it is driven.
module tb_motor_pwm_timebase;
    localparam int SIZE   = 16;
    localparam int PHASES = 3;
    localparam int PRE_W  = 8;

    typedef struct {
        int gap;
        int per;
        int duty0;
        bit done;
        bit run;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset = 1'b0;
    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;
    longint last_cyc = 0;
    bit     run_prev = 1'b0;
    exp_t   exp_q[$];
    exp_t   e;

    motor_pwm_timebase_if #(.SIZE(SIZE), .PHASES(PHASES), .PRE_W(PRE_W)) bus();

    motor_pwm_timebase #(.SIZE(SIZE), .PHASES(PHASES), .PRE_W(PRE_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cnt(input int v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.counter != SIZE'(v) && n < 3000);
        if (bus.counter != SIZE'(v)) chk("timeout_counter", bus.counter, v);
    endtask

    task automatic wait_wrap();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.wrap && n < 3000);
        if (!bus.wrap) chk("timeout_wrap", bus.wrap, 1);
    endtask

    task automatic setin(input int pre, input int per, input int d0, input int db);
        bus.prescale_in = PRE_W'(pre);
        bus.period_in   = SIZE'(per);
        bus.duty_in     = {SIZE'(3), SIZE'(2), SIZE'(d0)};
        bus.deadband_in = SIZE'(db);
    endtask

    task automatic expect_wrap(input int gap, input int per, input int d0, input bit done, input bit run);
        exp_q.push_back('{gap, per, d0, done, run});
    endtask

    // wrap monitor: gaps are measured from the first running clock or the previous wrap
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            run_prev = 1'b0;
        end else begin
            if (bus.running && !run_prev) last_cyc = cyc;
            if (bus.wrap) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wrap", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("wrap_gap", cyc - last_cyc, e.gap);
                    chk("wrap_period", bus.period, e.per);
                    chk("wrap_duty0", bus.duty[SIZE-1:0], e.duty0);
                    chk("wrap_load_done", bus.load_done, e.done);
                    chk("wrap_running", bus.running, e.run);
                end
                last_cyc = cyc;
            end
            run_prev = bus.running;
        end
    end

    initial begin
        bus.enable   = 1'b0;
        bus.load_req = 1'b0;
        setin(0, 0, 0, 0);
        bus.duty_in  = '0;
        tick(3);
        chk("rst_counter", bus.counter, 0);
        chk("rst_period", bus.period, 0);
        chk("rst_duty", bus.duty, 0);
        chk("rst_deadband", bus.deadband, 0);
        chk("rst_flags", {bus.wrap, bus.load_pending, bus.load_done, bus.running}, 0);
        reset = 1'b1;
        tick(2);
        setin(0, 1000, 500, 7);
        bus.load_req = 1'b1;
        tick(1);
        bus.load_req = 1'b0;
        chk("idle_load_ignored", bus.load_pending, 0);
        chk("idle_counter", bus.counter, 0);
        // basic count
        bus.enable = 1'b1;
        tick(1);
        chk("start_running", bus.running, 1);
        chk("start_period", bus.period, 1000);
        chk("start_duty0", bus.duty[SIZE-1:0], 500);
        chk("start_duty2", bus.duty[3*SIZE-1:2*SIZE], 3);
        chk("start_deadband", bus.deadband, 7);
        chk("start_counter", bus.counter, 0);
        tick(1);
        chk("count_1", bus.counter, 1);
        // staged update and ignored second request
        wait_cnt(200);
        setin(0, 600, 300, 9);
        bus.load_req = 1'b1;
        expect_wrap(1000, 600, 300, 1'b1, 1'b1);
        tick(1);
        bus.load_req = 1'b0;
        chk("stage_pending", bus.load_pending, 1);
        chk("stage_period_held", bus.period, 1000);
        chk("stage_duty_held", bus.duty[SIZE-1:0], 500);
        setin(0, 400, 111, 9);
        bus.load_req = 1'b1;
        tick(1);
        bus.load_req = 1'b0;
        wait_cnt(999);
        chk("pre_wrap_period", bus.period, 1000);
        chk("pre_wrap_pending", bus.load_pending, 1);
        wait_wrap();
        chk("apply_period", bus.period, 600);
        chk("apply_deadband", bus.deadband, 9);
        chk("apply_pending_clr", bus.load_pending, 0);
        tick(1);
        chk("done_pulse_width", bus.load_done, 0);
        // request captured on the wrap clock waits for the following wrap
        wait_cnt(599);
        setin(0, 800, 100, 9);
        bus.load_req = 1'b1;
        expect_wrap(600, 600, 300, 1'b0, 1'b1);
        expect_wrap(600, 800, 100, 1'b1, 1'b1);
        tick(1);
        bus.load_req = 1'b0;
        chk("wrapclk_wrap", bus.wrap, 1);
        chk("wrapclk_pending", bus.load_pending, 1);
        chk("wrapclk_period_held", bus.period, 600);
        wait_wrap();
        chk("wrapclk_applied", bus.period, 800);
        // drain with a set staged during the drain
        wait_cnt(300);
        bus.enable = 1'b0;
        tick(1);
        chk("drain_running", bus.running, 1);
        setin(0, 1000, 250, 4);
        bus.load_req = 1'b1;
        expect_wrap(800, 1000, 250, 1'b1, 1'b0);
        tick(1);
        bus.load_req = 1'b0;
        wait_cnt(799);
        chk("drain_reached_end", bus.running, 1);
        wait_wrap();
        chk("drain_counter", bus.counter, 0);
        chk("drain_stopped", bus.running, 0);
        tick(5);
        chk("idle_parked", bus.counter, 0);
        chk("idle_not_running", bus.running, 0);
        // restart, then cancel a drain by re-raising enable
        setin(0, 1000, 500, 4);
        bus.enable = 1'b1;
        tick(1);
        chk("run2_period", bus.period, 1000);
        chk("run2_pending", bus.load_pending, 0);
        wait_cnt(300);
        bus.enable = 1'b0;
        expect_wrap(1000, 1000, 500, 1'b0, 1'b1);
        wait_cnt(500);
        chk("run2_draining", bus.running, 1);
        bus.enable = 1'b1;
        wait_wrap();
        chk("run2_kept_running", bus.running, 1);
        tick(3);
        chk("run2_counting", bus.counter, 3);
        bus.enable = 1'b0;
        expect_wrap(1000, 1000, 500, 1'b0, 1'b0);
        wait_wrap();
        chk("run2_stopped", bus.running, 0);
        // prescale 3, period 10
        setin(3, 10, 20, 1);
        expect_wrap(40, 10, 20, 1'b0, 1'b1);
        expect_wrap(40, 10, 20, 1'b0, 1'b1);
        expect_wrap(40, 10, 20, 1'b0, 1'b0);
        bus.enable = 1'b1;
        tick(1);
        for (int k = 0; k < 12; k++) begin
            chk("prescale_cnt", bus.counter, k / 4);
            tick(1);
        end
        wait_wrap();
        wait_wrap();
        bus.enable = 1'b0;
        wait_wrap();
        chk("prescale_stopped", bus.running, 0);
        // period clamp, then a staged set applied at period 2
        setin(0, 0, 5, 0);
        expect_wrap(2, 2, 5, 1'b0, 1'b1);
        bus.enable = 1'b1;
        tick(1);
        chk("clamp_period", bus.period, 2);
        chk("clamp_cnt0a", bus.counter, 0);
        tick(1);
        chk("clamp_cnt1", bus.counter, 1);
        tick(1);
        chk("clamp_cnt0b", bus.counter, 0);
        chk("clamp_wrap", bus.wrap, 1);
        setin(0, 1000, 444, 0);
        bus.load_req = 1'b1;
        expect_wrap(2, 1000, 444, 1'b1, 1'b1);
        tick(1);
        bus.load_req = 1'b0;
        chk("clamp_cnt1b", bus.counter, 1);
        tick(1);
        chk("clamp_to_1000", bus.period, 1000);
        // asynchronous reset mid-period
        wait_cnt(450);
        chk("scoreboard_drained", exp_q.size(), 0);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_counter", bus.counter, 0);
        chk("async_rst_period", bus.period, 0);
        chk("async_rst_duty", bus.duty, 0);
        chk("async_rst_deadband", bus.deadband, 0);
        chk("async_rst_flags", {bus.wrap, bus.load_pending, bus.load_done, bus.running}, 0);
        bus.enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick(5);
        chk("post_rst_counter", bus.counter, 0);
        chk("post_rst_idle", bus.running, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
